uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter UART_BASE, default 0: Wishbone base address of the UART slave.
REQ-002 SHALL have parameter POLL_GAP, default 16: idle cycles between consecutive STAT polls while the UART is busy.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: cycles a bus cycle may wait for ack/err before it is aborted.
REQ-004 SHALL have one clock and a synchronous active-high reset, named clk_i and rst_i, with no other clock or reset.
REQ-005 Ports, clock and reset first (name, direction, width, meaning):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req0_valid_i  in  1  requester 0 has a byte
- req0_data_i  in  8  requester 0 byte
- req0_ready_o  out  1  one-cycle pulse: requester 0 byte is consumed
- req1_valid_i / req1_data_i / req1_ready_o: same as requester 0, for requester 1
- m_cyc_o  out  1  Wishbone cycle
- m_stb_o  out  1  Wishbone strobe
- m_we_o  out  1  Wishbone write enable
- m_adr_o  out  `ADR_WIDTH  Wishbone address
- m_dat_o  out  `DAT_WIDTH (64)  write data
- m_dat_i  in  `DAT_WIDTH  read data
- m_ack_i  in  1  Wishbone acknowledge
- m_err_i  in  1  Wishbone error
- busy_o  out  1  transfer in progress (state not IDLE)
- err_o  out  1  sticky error flag, cleared only by reset

Function
REQ-006 SHALL register every output; reset value of every output is 0.
REQ-007 States SHALL be IDLE, STAT_RD, STAT_GAP, WAIT, DATA_WR, DONE.
REQ-008 IDLE: if any valid is high, SHALL grant one requester, latch its byte, and enter STAT_RD on the next cycle.
REQ-009 Grant SHALL be round-robin with a 1-bit pointer: simultaneous valids go to the pointer's requester; a single valid is granted immediately regardless of the pointer.
REQ-010 STAT_RD: cyc=stb=1, we=0, adr=UART_BASE+0x00, held until m_ack_i or m_err_i.
REQ-011 On a STAT ack, SHALL capture m_dat_i[0] (TX busy) and enter STAT_GAP with cyc=stb=0 on the next cycle.
REQ-012 STAT_GAP: if the captured bit is 1, SHALL enter WAIT; if it is 0, SHALL enter DATA_WR.
REQ-013 WAIT: SHALL count POLL_GAP cycles with stb=0, then return to STAT_RD.
REQ-014 DATA_WR: cyc=stb=1, we=1, adr=UART_BASE+0x10, dat={56'h0, latched byte}, held until ack or err.
REQ-015 On a DATA ack, SHALL enter DONE with cyc=stb=0.
REQ-016 DONE: SHALL pulse the granted ready for exactly one cycle, toggle the pointer to the other requester, and return to IDLE.
REQ-017 Between any two strobed transfers, stb SHALL be low for at least one cycle, so the slave can return to its idle phase.
REQ-018 On m_err_i, or on ACK_TIMEOUT cycles without ack/err, SHALL drop cyc/stb, set err_o, and go to DONE: the byte is discarded but ready is still pulsed, so requesters never stall.
REQ-019 m_ack_i or m_err_i arriving while stb=0 SHALL be ignored.
REQ-020 The latched byte is used; req*_data_i changes after grant SHALL have no effect.
REQ-021 Deasserting valid after grant SHALL NOT cancel the transfer.
REQ-022 Throughput SHALL be one byte per UART frame; no back-to-back DATA write is issued without an intervening STAT read reporting not-busy.

Reset
REQ-023 rst_i SHALL force IDLE, pointer=0, counters=0, err_o=0, and all outputs to 0 on the next clock edge.
REQ-024 Reset mid-transfer SHALL drop cyc/stb in the same edge, discard the latched byte, and emit no ready pulse.

Structure
REQ-025 UART register offsets (STAT 0x00, CTRL 0x08, DATA 0x10) and STAT bit positions (bit0 TX busy, bit1 RX ready) SHALL live in a shared header used by both the UART and this block; FSM state encodings stay local.
REQ-026 The Wishbone single-transfer sequencer (strobe, ack/err/timeout, one-cycle gap) SHALL be the sub-module wb_single_xfer; arbitration and polling stay in uart_tx_sched.

Verification
REQ-027 req0 valid with 0x41, STAT returns 0 -> exactly one STAT read, then a DATA write of 0x41 at BASE+0x10, then req0_ready pulses for 1 cycle.
REQ-028 STAT returns 1 three times, then 0 -> 4 STAT reads, each pair separated by >=POLL_GAP stb-low cycles, then one DATA write.
REQ-029 req0 and req1 both valid continuously with 0x11 and 0x22 -> bytes are written alternating 0x11, 0x22, 0x11, with req0 first after reset.
REQ-030 Slave asserts m_err_i on the DATA write -> err_o=1 and stays 1, ready pulses, the next byte is still transferred.
REQ-031 Slave never acks -> after 255 cycles cyc=stb=0, err_o=1, FSM is back in IDLE.
REQ-032 rst_i asserted during DATA_WR -> stb=0 on the next cycle, no ready pulse, no further bus activity until a new valid.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared UART register map and bus widths for the UART slave and its bus masters.
// Latency: n/a (constants and a pure address helper only).
// Backpressure: n/a.
//
// Register offsets and STAT bit positions are macros, so a plain Verilog UART
// model can consume them without importing the package. The package carries
// the bus widths and the address helper used by SystemVerilog masters.

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

`ifndef UART_REGS_DEFINED
`define UART_REGS_DEFINED
`define UART_STAT_OFS     8'h00
`define UART_CTRL_OFS     8'h08
`define UART_DATA_OFS     8'h10
`define UART_STAT_TXBUSY  0
`define UART_STAT_RXRDY   1
`endif

package uart_tx_sched_pkg;

    localparam int ADR_W = `ADR_WIDTH;
    localparam int DAT_W = `DAT_WIDTH;

    // Absolute register address from the slave base and an 8-bit offset.
    function automatic logic [ADR_W-1:0] uart_reg_adr(input logic [ADR_W-1:0] base,
                                                      input logic [7:0]       ofs);
        return base + {{(ADR_W-8){1'b0}}, ofs};
    endfunction

endpackage

// File: rtl/uart_tx_sched_xfer.sv
// Wishbone single-transfer sequencer: one strobed cycle per start, ended by ack, err or timeout.
// Latency: cyc/stb rise on the edge that accepts start_i; they drop on the edge that samples ack/err/timeout.
// Backpressure: start_i is only accepted while idle, so stb is always low for at least one cycle between transfers.
//
// Ports: clk_i/rst_i; start_i + we_i/adr_i/dat_i request a transfer; cyc_o/stb_o/we_o/adr_o/dat_o
// are the registered bus outputs; ack_i/err_i from the slave; done_o (transfer ends this cycle)
// and fail_o (it ends with err or timeout) are combinational and valid only while stb_o is high.

module wb_single_xfer
    import uart_tx_sched_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             we_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [DAT_W-1:0] dat_i,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    input  logic             ack_i,
    input  logic             err_i,
    output logic             done_o,
    output logic             fail_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             timeout;

    // The timer starts at 0 on the first strobed cycle, so the slave gets
    // exactly ACK_TIMEOUT strobed cycles before the abort.
    assign timeout = (tmr_q == TW'(ACK_TIMEOUT - 1));

    // Responses arriving while stb is low are ignored by construction.
    assign done_o  = stb_q & (ack_i | err_i | timeout);
    // err wins over a simultaneous ack.
    assign fail_o  = stb_q & (err_i | (timeout & ~ack_i));

    always_comb begin
        stb_d = stb_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        tmr_d = tmr_q;
        if (stb_q) begin
            if (done_o) begin
                stb_d = 1'b0;
                we_d  = 1'b0;
                adr_d = '0;
                dat_d = '0;
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end else if (start_i) begin
            stb_d = 1'b1;
            we_d  = we_i;
            adr_d = adr_i;
            dat_d = dat_i;
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            tmr_q <= '0;
        end else begin
            stb_q <= stb_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            tmr_q <= tmr_d;
        end
    end

    // Single-transfer master: cyc and strobe always move together.
    assign cyc_o = stb_q;
    assign stb_o = stb_q;
    assign we_o  = we_q;
    assign adr_o = adr_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler that polls UART STAT until TX is idle, then writes the byte to DATA.
// Latency: grant in IDLE, STAT read next cycle; ready pulses one cycle after the DATA write completes.
// Backpressure: a requester holds its byte until its one-cycle ready pulse; errors still pulse ready.
//
// Ports: clk_i/rst_i; reqN_valid_i/reqN_data_i/reqN_ready_o per requester; m_* Wishbone master;
// busy_o (not IDLE) and err_o (sticky bus error/timeout, cleared only by reset). All outputs registered.

module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter logic [`ADR_WIDTH-1:0] UART_BASE   = '0,
    parameter int                    POLL_GAP    = 16,
    parameter int                    ACK_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    input  logic [7:0]            req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [7:0]            req1_data_i,
    output logic                  req1_ready_o,
    output logic                  m_cyc_o,
    output logic                  m_stb_o,
    output logic                  m_we_o,
    output logic [`ADR_WIDTH-1:0] m_adr_o,
    output logic [`DAT_WIDTH-1:0] m_dat_o,
    input  logic [`DAT_WIDTH-1:0] m_dat_i,
    input  logic                  m_ack_i,
    input  logic                  m_err_i,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        IDLE,
        STAT_RD,
        STAT_GAP,
        WAIT,
        DATA_WR,
        DONE
    } state_t;

    localparam int WW = $clog2(POLL_GAP + 1);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;       // requester favoured on a tie
    logic          gnt_q, gnt_d;       // requester being served
    logic [7:0]    byte_q, byte_d;
    logic          txbusy_q, txbusy_d; // TX-busy bit from the last STAT read
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          rdy0_q, rdy0_d;
    logic          rdy1_q, rdy1_d;
    logic          busy_q, busy_d;

    logic             xfer_start;
    logic             xfer_we;
    logic [ADR_W-1:0] xfer_adr;
    logic [DAT_W-1:0] xfer_dat;
    logic             xfer_done;
    logic             xfer_fail;
    logic             gnt_now;

    // Only the TX-busy bit of STAT matters here.
    logic unused_dat;
    assign unused_dat = ^m_dat_i;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        byte_d     = byte_q;
        txbusy_d   = txbusy_q;
        wait_d     = wait_q;
        err_d      = err_q;
        rdy0_d     = 1'b0;
        rdy1_d     = 1'b0;
        xfer_start = 1'b0;
        xfer_we    = 1'b0;
        xfer_adr   = '0;
        xfer_dat   = '0;
        gnt_now    = (req0_valid_i & req1_valid_i) ? ptr_q : req1_valid_i;

        case (state_q)
            IDLE: begin
                if (req0_valid_i | req1_valid_i) begin
                    gnt_d      = gnt_now;
                    byte_d     = gnt_now ? req1_data_i : req0_data_i;
                    xfer_start = 1'b1;
                    xfer_adr   = uart_reg_adr(UART_BASE, `UART_STAT_OFS);
                    state_d    = STAT_RD;
                end
            end
            STAT_RD: begin
                if (xfer_done) begin
                    if (xfer_fail) begin
                        err_d   = 1'b1;
                        rdy0_d  = ~gnt_q;
                        rdy1_d  = gnt_q;
                        state_d = DONE;
                    end else begin
                        txbusy_d = m_dat_i[`UART_STAT_TXBUSY];
                        state_d  = STAT_GAP;
                    end
                end
            end
            STAT_GAP: begin
                if (txbusy_q) begin
                    wait_d  = '0;
                    state_d = WAIT;
                end else begin
                    xfer_start = 1'b1;
                    xfer_we    = 1'b1;
                    xfer_adr   = uart_reg_adr(UART_BASE, `UART_DATA_OFS);
                    xfer_dat   = {{(DAT_W-8){1'b0}}, byte_q};
                    state_d    = DATA_WR;
                end
            end
            WAIT: begin
                // STAT_GAP already gave one low cycle; WAIT adds POLL_GAP more.
                if (wait_q == WW'(POLL_GAP - 1)) begin
                    wait_d     = '0;
                    xfer_start = 1'b1;
                    xfer_adr   = uart_reg_adr(UART_BASE, `UART_STAT_OFS);
                    state_d    = STAT_RD;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            DATA_WR: begin
                if (xfer_done) begin
                    if (xfer_fail) begin
                        err_d = 1'b1;
                    end
                    rdy0_d  = ~gnt_q;
                    rdy1_d  = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = ~gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            byte_q   <= '0;
            txbusy_q <= 1'b0;
            wait_q   <= '0;
            err_q    <= 1'b0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            byte_q   <= byte_d;
            txbusy_q <= txbusy_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            rdy0_q   <= rdy0_d;
            rdy1_q   <= rdy1_d;
            busy_q   <= busy_d;
        end
    end

    assign req0_ready_o = rdy0_q;
    assign req1_ready_o = rdy1_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

    wb_single_xfer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(xfer_start),
        .we_i   (xfer_we),
        .adr_i  (xfer_adr),
        .dat_i  (xfer_dat),
        .cyc_o  (m_cyc_o),
        .stb_o  (m_stb_o),
        .we_o   (m_we_o),
        .adr_o  (m_adr_o),
        .dat_o  (m_dat_o),
        .ack_i  (m_ack_i),
        .err_i  (m_err_i),
        .done_o (xfer_done),
        .fail_o (xfer_fail)
    );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a randomized two-requester run.
// Latency: n/a.
// Backpressure: requester models hold each byte until its ready pulse.

module tb_uart_tx_sched;
    import uart_tx_sched_pkg::*;

    localparam logic [ADR_W-1:0] BASE = 32'h4000_0100;
    localparam int PGAP = 4;
    localparam int TMO  = 255;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             req0_valid_i, req1_valid_i;
    logic [7:0]       req0_data_i, req1_data_i;
    logic             req0_ready_o, req1_ready_o;
    logic             m_cyc_o, m_stb_o, m_we_o;
    logic [ADR_W-1:0] m_adr_o;
    logic [DAT_W-1:0] m_dat_o, m_dat_i;
    logic             m_ack_i, m_err_i;
    logic             busy_o, err_o;

    always #5 clk = ~clk;

    uart_tx_sched #(.UART_BASE(BASE), .POLL_GAP(PGAP), .ACK_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Slave / requester model state and observation logs.
    bit         sl_silent = 0, sl_err_next = 0, sl_noise = 0;
    int         sl_lat = 0;          // fixed ack latency, or -1 for random 0..2
    bit         stat_q[$];           // TX-busy bits returned by successive STAT reads
    logic [7:0] q0[$], q1[$];        // bytes each requester still has to send
    logic [7:0] wr_log[$];           // bytes accepted by DATA writes
    int         rdy_log[$];          // requester id of each ready pulse
    int         n_stat = 0, n_data = 0, fmt_bad = 0, b2b = 0, rdy_bad = 0;
    int         min_gap = 1000, last_hi = 0;

    function automatic logic [63:0] wr_at(input int i);
        return (i < wr_log.size()) ? {56'h0, wr_log[i]} : 64'hDEAD;
    endfunction

    function automatic logic [63:0] rdy_at(input int i);
        return (i < rdy_log.size()) ? 64'(rdy_log[i]) : 64'hDEAD;
    endfunction

    // Wishbone UART slave.
    initial begin : slave
        bit active = 0, acked = 0, last_stat = 0;
        int wait_n = 0, low_run = 0, cur_hi = 0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_dat_i = '0;
        forever begin
            @(negedge clk);
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            if (m_cyc_o !== m_stb_o) fmt_bad++;
            if (m_stb_o) begin
                cur_hi++;
                if (acked) b2b++;   // strobe still high after a response was taken
                acked = 0;
                if (!active) begin
                    active = 1;
                    wait_n = (sl_lat < 0) ? int'($urandom_range(0, 2)) : sl_lat;
                    if (m_we_o) begin
                        n_data++;
                        if (m_adr_o !== BASE + 32'h10 || m_dat_o[63:8] !== 56'h0) fmt_bad++;
                        last_stat = 0;
                    end else begin
                        n_stat++;
                        if (m_adr_o !== BASE) fmt_bad++;
                        if (last_stat && low_run < min_gap) min_gap = low_run;
                        last_stat = 1;
                    end
                end
                low_run = 0;
                if (!sl_silent) begin
                    if (wait_n == 0) begin
                        if (m_we_o) begin
                            if (sl_err_next) begin
                                m_err_i = 1'b1;
                                sl_err_next = 0;
                            end else begin
                                m_ack_i = 1'b1;
                                wr_log.push_back(m_dat_o[7:0]);
                            end
                        end else begin
                            m_dat_i = {$urandom, $urandom};
                            m_dat_i[0] = (stat_q.size() > 0) ? stat_q.pop_front() : 1'b0;
                            m_ack_i = 1'b1;
                        end
                        acked = 1;
                        active = 0;
                    end else begin
                        wait_n--;
                    end
                end
            end else begin
                if (cur_hi > 0) last_hi = cur_hi;
                cur_hi = 0;
                active = 0;
                acked = 0;
                low_run++;
                if (sl_noise) begin
                    m_ack_i = ($urandom_range(0, 3) == 0);
                    m_err_i = ($urandom_range(0, 5) == 0);
                end
            end
        end
    end

    // Requesters: hold the head byte while idle; scramble data and valid once the scheduler is busy.
    initial begin : reqs
        bit p0 = 0, p1 = 0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        req0_data_i  = '0;
        req1_data_i  = '0;
        forever begin
            @(negedge clk);
            if (req0_ready_o && req1_ready_o) rdy_bad++;
            if ((req0_ready_o && p0) || (req1_ready_o && p1)) rdy_bad++;
            p0 = req0_ready_o;
            p1 = req1_ready_o;
            if (req0_ready_o) begin
                rdy_log.push_back(0);
                if (q0.size() > 0) q0.delete(0);
            end
            if (req1_ready_o) begin
                rdy_log.push_back(1);
                if (q1.size() > 0) q1.delete(0);
            end
            req0_valid_i = (q0.size() > 0) && (!busy_o || $urandom_range(0, 1) == 1);
            req1_valid_i = (q1.size() > 0) && (!busy_o || $urandom_range(0, 1) == 1);
            req0_data_i  = (busy_o || q0.size() == 0) ? 8'($urandom) : q0[0];
            req1_data_i  = (busy_o || q1.size() == 0) ? 8'($urandom) : q1[0];
        end
    end

    task automatic clear_logs();
        q0.delete(); q1.delete(); stat_q.delete(); wr_log.delete(); rdy_log.delete();
        n_stat = 0; n_data = 0; fmt_bad = 0; b2b = 0; rdy_bad = 0; min_gap = 1000;
        sl_silent = 0; sl_err_next = 0; sl_noise = 0; sl_lat = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_logs();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        clear_logs();
    endtask

    task automatic wait_ready(input int n, input int budget, input string tag);
        int c = 0;
        while (rdy_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_ready_cnt"}, 64'(rdy_log.size() >= n), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin : main
        logic [7:0] e0[$], e1[$], exp_b[$];
        int exp_id[$];
        int exp_stat, nb, ptr, g, c;
        bit found;

        // Reset state.
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc_stb_we", {61'h0, m_cyc_o, m_stb_o, m_we_o}, 64'd0);
        check("rst_adr", 64'(m_adr_o), 64'd0);
        check("rst_dat", m_dat_o, 64'd0);
        check("rst_flags", {60'h0, busy_o, err_o, req0_ready_o, req1_ready_o}, 64'd0);

        // One byte, UART idle.
        do_reset();
        stat_q.push_back(1'b0);
        q0.push_back(8'h41);
        wait_ready(1, 300, "A");
        check("A_nstat", 64'(n_stat), 64'd1);
        check("A_ndata", 64'(n_data), 64'd1);
        check("A_byte", wr_at(0), 64'h41);
        check("A_rdy_id", rdy_at(0), 64'd0);
        check("A_rdy_n", 64'(rdy_log.size()), 64'd1);
        check("A_rdy_width", 64'(rdy_bad), 64'd0);
        check("A_fmt", 64'(fmt_bad), 64'd0);
        check("A_idle", {62'h0, busy_o, err_o}, 64'd0);

        // Busy three times before idle.
        do_reset();
        stat_q = '{1'b1, 1'b1, 1'b1, 1'b0};
        q1.push_back(8'h5A);
        wait_ready(1, 500, "B");
        check("B_nstat", 64'(n_stat), 64'd4);
        check("B_ndata", 64'(n_data), 64'd1);
        check("B_poll_gap_ok", 64'(min_gap >= PGAP), 64'd1);
        check("B_byte", wr_at(0), 64'h5A);
        check("B_rdy_id", rdy_at(0), 64'd1);

        // Both requesters valid: alternate, req0 first after reset.
        do_reset();
        q0 = '{8'h11, 8'h11};
        q1 = '{8'h22};
        wait_ready(3, 600, "C");
        check("C_wr0", wr_at(0), 64'h11);
        check("C_wr1", wr_at(1), 64'h22);
        check("C_wr2", wr_at(2), 64'h11);
        check("C_id1", rdy_at(1), 64'd1);
        check("C_b2b", 64'(b2b), 64'd0);

        // Error on the DATA write: byte dropped, ready still pulses, next byte goes through.
        do_reset();
        sl_err_next = 1;
        q0 = '{8'h33, 8'h44};
        wait_ready(2, 600, "D");
        check("D_err", 64'(err_o), 64'd1);
        check("D_nwr", 64'(wr_log.size()), 64'd1);
        check("D_byte", wr_at(0), 64'h44);
        check("D_ids", {rdy_at(0)[31:0], rdy_at(1)[31:0]}, 64'd0);
        repeat (20) @(negedge clk);
        check("D_err_sticky", 64'(err_o), 64'd1);

        // Slave never answers: abort after the timeout.
        do_reset();
        sl_silent = 1;
        q1.push_back(8'h77);
        wait_ready(1, 600, "E");
        check("E_stb_cycles", 64'(last_hi), 64'(TMO));
        check("E_bus_idle", {62'h0, m_cyc_o, m_stb_o}, 64'd0);
        check("E_err", 64'(err_o), 64'd1);
        check("E_busy", 64'(busy_o), 64'd0);
        check("E_ndata", 64'(n_data), 64'd0);
        sl_silent = 0;

        // Reset during the DATA write.
        do_reset();
        sl_lat = 3;
        stat_q.push_back(1'b0);
        q0.push_back(8'h99);
        found = 0;
        c = 0;
        while (!found && c < 300) begin
            @(negedge clk);
            c++;
            found = m_stb_o && m_we_o;
        end
        check("F_reach_data_wr", 64'(found), 64'd1);
        rst_i = 1'b1;
        q0.delete();
        @(negedge clk);
        check("F_stb_drop", {62'h0, m_cyc_o, m_stb_o}, 64'd0);
        rst_i = 1'b0;
        repeat (60) @(negedge clk);
        check("F_no_more_bus", 64'(n_stat + n_data), 64'd2);
        check("F_no_ready", 64'(rdy_log.size()), 64'd0);
        check("F_no_write", 64'(wr_log.size()), 64'd0);
        check("F_idle", {62'h0, busy_o, err_o}, 64'd0);

        // Randomized traffic against a queue-level model.
        do_reset();
        sl_lat = -1;
        sl_noise = 1;
        exp_stat = 0;
        e0.delete(); e1.delete(); exp_b.delete(); exp_id.delete();
        repeat ($urandom_range(4, 10)) e0.push_back(8'($urandom));
        repeat ($urandom_range(4, 10)) e1.push_back(8'($urandom));
        nb = e0.size() + e1.size();
        for (int i = 0; i < nb; i++) begin
            int k = $urandom_range(0, 2);
            repeat (k) stat_q.push_back(1'b1);
            stat_q.push_back(1'b0);
            exp_stat += k + 1;
        end
        ptr = 0;
        while (e0.size() > 0 || e1.size() > 0) begin
            g = (e0.size() > 0 && e1.size() > 0) ? ptr : (e0.size() > 0 ? 0 : 1);
            if (g == 0) begin
                q0.push_back(e0[0]); exp_b.push_back(e0[0]); e0.delete(0);
            end else begin
                q1.push_back(e1[0]); exp_b.push_back(e1[0]); e1.delete(0);
            end
            exp_id.push_back(g);
            ptr = 1 - g;
        end
        wait_ready(nb, 20000, "G");
        for (int i = 0; i < nb; i++) begin
            check($sformatf("G_byte%0d", i), wr_at(i), {56'h0, exp_b[i]});
            check($sformatf("G_id%0d", i), rdy_at(i), 64'(exp_id[i]));
        end
        check("G_nstat", 64'(n_stat), 64'(exp_stat));
        check("G_ndata", 64'(n_data), 64'(nb));
        check("G_err_clear", 64'(err_o), 64'd0);
        check("G_poll_gap_ok", 64'(min_gap >= PGAP), 64'd1);
        check("G_fmt", 64'(fmt_bad), 64'd0);
        check("G_b2b", 64'(b2b), 64'd0);
        check("G_rdy_width", 64'(rdy_bad), 64'd0);
        sl_noise = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
